// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - shared types and constants for counter_ctrl
// Purpose: FSM state enum, synchroniser depth and default parameter values
//          shared by counter_ctrl and btn_debounce.
// Ports:   none (package).
package counter_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      UP_HELD   = 2'd1,
      DOWN_HELD = 2'd2,
      LOCKOUT   = 2'd3
   } state_t;

   localparam int SYNC_STAGES           = 2;
   localparam int DEF_DEBOUNCE_CYCLES   = 4;
   localparam int DEF_REPEAT_DELAY      = 16;
   localparam int DEF_REPEAT_PERIOD     = 4;

endpackage

// File: rtl/counter_ctrl_btn_debounce.sv
// rtl/counter_ctrl_btn_debounce.sv - button synchroniser plus debounce filter
// Purpose: brings a raw asynchronous button into the clk domain and only lets
//          the debounced level follow it after DEBOUNCE_CYCLES consecutive
//          differing samples.
// Ports:   clk   - clock
//          rst   - synchronous active-high reset
//          btn   - raw asynchronous button
//          level - debounced level
module btn_debounce
   import counter_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic level
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

   logic [SYNC_STAGES-1:0] sync;
   logic [CW-1:0]          cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync  <= '0;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], btn};
         // Any sample agreeing with the current level restarts the run, so
         // only an unbroken run of differing samples can flip the level.
         if (sync[SYNC_STAGES-1] == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            level <= ~level;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - push-button front end producing counter enable/direction
// Purpose: debounces btn_up/btn_down and turns each accepted press into a
//          single-cycle enable with a matching direction. Pressing one button
//          while the other is held locks out counting until both are released.
//          Optional auto-repeat while a single button is held is built when
//          COUNTER_CTRL_AUTO_REPEAT_EN is defined.
// Ports:   clk       - clock
//          rst       - synchronous active-high reset
//          btn_up    - raw up button, active high
//          btn_down  - raw down button, active high
//          enable    - one-cycle count request
//          direction - 1 = up, 0 = down; held between pulses
module counter_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_up,
   input  logic btn_down,
   output logic enable,
   output logic direction
);

   logic   db_up;
   logic   db_down;
   state_t state_q;
   state_t state_d;
   logic   enable_d;
   logic   direction_d;
   logic   press;
   logic   held;
   logic   rep_fire;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_up),
      .level (db_up)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_down),
      .level (db_down)
   );

   // A press is accepted only from IDLE with exactly one button down.
   assign press = (state_q == IDLE) && (db_up ^ db_down);
   assign held  = (state_q == UP_HELD) || (state_q == DOWN_HELD);

`ifdef COUNTER_CTRL_AUTO_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX) + 1;

   logic [RW-1:0] rpt_cnt;

   // Down-counter loaded on the initial pulse; reaching zero while the held
   // state persists fires a repeat and reloads with the period.
   always_ff @(posedge clk) begin
      if (rst) begin
         rpt_cnt <= '0;
      end else if (press) begin
         rpt_cnt <= RW'(REPEAT_DELAY - 1);
      end else if (held && (state_d == state_q)) begin
         if (rpt_cnt == '0) begin
            rpt_cnt <= RW'(REPEAT_PERIOD - 1);
         end else begin
            rpt_cnt <= rpt_cnt - 1'b1;
         end
      end else begin
         rpt_cnt <= '0;
      end
   end

   assign rep_fire = held && (state_d == state_q) && (rpt_cnt == '0);
`else
   logic unused_repeat_cfg;
   assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD, held};
   assign rep_fire          = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         enable    <= 1'b0;
         direction <= 1'b0;
      end else begin
         state_q   <= state_d;
         enable    <= enable_d;
         direction <= direction_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (db_up && db_down) state_d = LOCKOUT;
            else if (db_up)       state_d = UP_HELD;
            else if (db_down)     state_d = DOWN_HELD;
         end
         UP_HELD: begin
            if (db_down)     state_d = LOCKOUT;
            else if (!db_up) state_d = IDLE;
         end
         DOWN_HELD: begin
            if (db_up)         state_d = LOCKOUT;
            else if (!db_down) state_d = IDLE;
         end
         LOCKOUT: begin
            if (!db_up && !db_down) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      enable_d    = press | rep_fire;
      direction_d = press ? db_up : direction;
   end

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - self-checking bench for counter_ctrl
module tb_counter_ctrl;

   localparam int D   = 4;
   localparam int LAT = D + 3;
   localparam int RD  = 16;
   localparam int RP  = 4;

   logic clk       = 1'b0;
   logic rst       = 1'b1;
   logic btn_up    = 1'b1;
   logic btn_down  = 1'b1;
   logic enable;
   logic direction;

   int   edge_n = 0;
   int   n_vec  = 0;
   int   n_bad  = 0;
   logic prev_en = 1'b0;

   typedef struct {
      int   edge_no;
      logic dir;
   } exp_t;

   typedef struct {
      logic up;
      logic down;
      int   dur;
      logic pulse;
      logic pdir;
      logic exp_dir;
   } seg_t;

   exp_t sb[$];
   seg_t segs[16];

   counter_ctrl #(
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .enable    (enable),
      .direction (direction)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic act, input logic req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %b, required %b (edge %0d)", nm, act, req, edge_n);
      end
   endtask

   // Called at a negedge just as the new button level is driven; the press is
   // first sampled at the next edge and the pulse is registered LAT edges on.
   task automatic push_press(input logic dir, input int dur);
      exp_t e;
      e.edge_no = edge_n + LAT;
      e.dir     = dir;
      sb.push_back(e);
`ifdef COUNTER_CTRL_AUTO_REPEAT_EN
      for (int t = RD; t < dur; t += RP) begin
         exp_t r;
         r.edge_no = edge_n + LAT + t;
         r.dir     = dir;
         sb.push_back(r);
      end
`else
      if (dur < 0) $display("negative hold %0d", dur);
`endif
   endtask

   always @(posedge clk) begin
      edge_n = edge_n + 1;
      #1;
      while (sb.size() > 0 && sb[0].edge_no < edge_n) begin
         n_vec++;
         n_bad++;
         $display("FAIL pulse_missing: enable stayed 0 at edge %0d, required 1 dir=%b",
                  sb[0].edge_no, sb[0].dir);
         void'(sb.pop_front());
      end
      if (enable === 1'b1) begin
         chk("no_back_to_back", prev_en, 1'b0);
         chk("pulse_expected", (sb.size() > 0) && (sb[0].edge_no == edge_n), 1'b1);
         if (sb.size() > 0 && sb[0].edge_no == edge_n) begin
            chk("pulse_direction", direction, sb[0].dir);
            void'(sb.pop_front());
         end
      end
      prev_en = enable;
   end

   initial begin
      //          up    down  dur pulse pdir  exp_dir
      segs[0]  = '{1'b1, 1'b0, 30, 1'b1, 1'b1, 1'b1};  // plain up press
      segs[1]  = '{1'b0, 1'b0, 20, 1'b0, 1'b0, 1'b1};
      segs[2]  = '{1'b0, 1'b1,  3, 1'b0, 1'b0, 1'b1};  // glitch, rejected
      segs[3]  = '{1'b0, 1'b0, 20, 1'b0, 1'b0, 1'b1};
      segs[4]  = '{1'b0, 1'b1, 10, 1'b1, 1'b0, 1'b0};  // down press
      segs[5]  = '{1'b0, 1'b0, 20, 1'b0, 1'b0, 1'b0};
      segs[6]  = '{1'b1, 1'b1, 20, 1'b0, 1'b0, 1'b0};  // simultaneous
      segs[7]  = '{1'b0, 1'b0, 20, 1'b0, 1'b0, 1'b0};
      segs[8]  = '{1'b1, 1'b0, 20, 1'b1, 1'b1, 1'b1};  // up held
      segs[9]  = '{1'b1, 1'b1, 15, 1'b0, 1'b0, 1'b1};  // down joins: lockout
      segs[10] = '{1'b0, 1'b1, 15, 1'b0, 1'b0, 1'b1};  // up leaves, down held
      segs[11] = '{1'b0, 1'b0, 20, 1'b0, 1'b0, 1'b1};
      segs[12] = '{1'b0, 1'b1, 12, 1'b1, 1'b0, 1'b0};  // fresh down press
      segs[13] = '{1'b0, 1'b0, 20, 1'b0, 1'b0, 1'b0};
      segs[14] = '{1'b1, 1'b0, 12, 1'b1, 1'b1, 1'b1};
      segs[15] = '{1'b0, 1'b0, 20, 1'b0, 1'b0, 1'b1};

      // Reset held 3 cycles with both buttons pressed.
      repeat (3) begin
         @(negedge clk);
         chk("reset_enable", enable, 1'b0);
         chk("reset_direction", direction, 1'b0);
      end
      rst      = 1'b0;
      btn_down = 1'b0;
      push_press(1'b1, 15);
      repeat (15) @(negedge clk);
      btn_up = 1'b0;
      repeat (20) @(negedge clk);
      chk("post_reset_direction", direction, 1'b1);

      for (int i = 0; i < 16; i++) begin
         btn_up   = segs[i].up;
         btn_down = segs[i].down;
         if (segs[i].pulse) push_press(segs[i].pdir, segs[i].dur);
         repeat (segs[i].dur) @(negedge clk);
         chk($sformatf("seg%0d_direction", i), direction, segs[i].exp_dir);
      end

      // Reset two cycles into the debounce of an up press, button kept held.
      btn_up = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("midop_reset_enable", enable, 1'b0);
      chk("midop_reset_direction", direction, 1'b0);
      rst = 1'b0;
      push_press(1'b1, 20);
      repeat (20) @(negedge clk);
      btn_up = 1'b0;
      repeat (20) @(negedge clk);
      chk("midop_final_direction", direction, 1'b1);

`ifdef COUNTER_CTRL_AUTO_REPEAT_EN
      btn_up = 1'b1;
      push_press(1'b1, 40);
      repeat (40) @(negedge clk);
      btn_up = 1'b0;
      repeat (25) @(negedge clk);
`endif

      repeat (5) @(negedge clk);
      while (sb.size() > 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL pulse_pending: expected enable at edge %0d never seen", sb[0].edge_no);
         void'(sb.pop_front());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
